// File: rtl/lite16_pkg.sv
// Shared LITE-16 register-file constants, the register index type and the
// write-back skid state encoding.
package lite16_pkg;

  localparam int REG_COUNT = 16;
  localparam int REG_W     = 16;
  localparam int IDX_W     = 4;

  typedef logic [IDX_W-1:0] reg_idx_t;

  localparam logic [0:0] SKID_EMPTY = 1'b0;
  localparam logic [0:0] SKID_FULL  = 1'b1;

endpackage

// File: rtl/onehot_decoder.sv
// Index-to-one-hot decoder with enable; an all-zero output when disabled.
module onehot_decoder #(
  parameter int IDX_W = 4,
  parameter int OUT_W = 16
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/writeback_unit.sv
// LITE-16 write-back stage: arbitrates mem/ALU results onto the register-file write port and
// tracks outstanding loads. Optional bypass outputs via macro WRITEBACK_FORWARDING_EN.
module writeback_unit
  import lite16_pkg::*;
#(
  parameter int REG_COUNT = lite16_pkg::REG_COUNT,
  parameter int REG_W     = lite16_pkg::REG_W,
  parameter int IDX_W     = lite16_pkg::IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic                 issue_load,
  input  logic [IDX_W-1:0]     issue_rd,
  input  logic                 alu_valid,
  input  logic [IDX_W-1:0]     alu_rd,
  input  logic [REG_W-1:0]     alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [IDX_W-1:0]     mem_rd,
  input  logic [REG_W-1:0]     mem_data,
  output logic [REG_W-1:0]     wr_data,
  output logic [REG_COUNT-1:0] wr_en,
  output logic [REG_COUNT-1:0] pending,
  output logic                 busy,
  output logic                 err
`ifdef WRITEBACK_FORWARDING_EN
  ,
  output logic                 fwd_valid,
  output logic [IDX_W-1:0]     fwd_rd,
  output logic [REG_W-1:0]     fwd_data
`endif
);

  logic [0:0]           state_q, state_d;
  logic [IDX_W-1:0]     skid_rd_q, skid_rd_d;
  logic [REG_W-1:0]     skid_data_q, skid_data_d;
  logic [REG_W-1:0]     wr_data_q;
  logic [REG_COUNT-1:0] wr_en_q;
  logic [REG_COUNT-1:0] pending_q, pending_d;
  logic                 err_q, err_d;

  logic                 alu_acc;
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_rd;
  logic [REG_W-1:0]     sel_data;
  logic [REG_COUNT-1:0] sel_onehot;

  assign alu_ready = (state_q == SKID_EMPTY);
  assign alu_acc   = alu_valid && alu_ready;

  // Memory always wins; a colliding ALU result parks in the skid and drains next free cycle.
  always_comb begin
    state_d     = state_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    sel_valid   = 1'b0;
    sel_rd      = '0;
    sel_data    = '0;
    if (mem_valid) begin
      sel_valid = 1'b1;
      sel_rd    = mem_rd;
      sel_data  = mem_data;
      if (alu_acc) begin
        skid_rd_d   = alu_rd;
        skid_data_d = alu_data;
        state_d     = SKID_FULL;
      end
    end else if (state_q == SKID_FULL) begin
      sel_valid = 1'b1;
      sel_rd    = skid_rd_q;
      sel_data  = skid_data_q;
      state_d   = SKID_EMPTY;
    end else if (alu_acc) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end
  end

  onehot_decoder #(
    .IDX_W(IDX_W),
    .OUT_W(REG_COUNT)
  ) u_wr_dec (
    .en    (sel_valid),
    .idx   (sel_rd),
    .onehot(sel_onehot)
  );

  // Clear before set so an issue and a return to the same register leave it pending.
  always_comb begin
    pending_d = pending_q;
    if (mem_valid) pending_d[mem_rd] = 1'b0;
    if (issue_valid && issue_load) pending_d[issue_rd] = 1'b1;
    err_d = err_q | (mem_valid & ~pending_q[mem_rd]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SKID_EMPTY;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
      wr_en_q     <= '0;
      wr_data_q   <= '0;
      pending_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
      wr_en_q     <= sel_onehot;
      if (sel_valid) wr_data_q <= sel_data;
      pending_q   <= pending_d;
      err_q       <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;
  assign err     = err_q;
  assign busy    = (state_q == SKID_FULL) || (|pending_q);

`ifdef WRITEBACK_FORWARDING_EN
  assign fwd_valid = sel_valid;
  assign fwd_rd    = sel_rd;
  assign fwd_data  = sel_data;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Table-driven bench for writeback_unit with a scoreboard queue of expected post-edge state.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_load;
  logic [3:0]  issue_rd;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic [15:0] wr_data, wr_en, pending;
  logic        busy, err;
`ifdef WRITEBACK_FORWARDING_EN
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [15:0] fwd_data;
`endif

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_load (issue_load),
    .issue_rd   (issue_rd),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .pending    (pending),
    .busy       (busy),
    .err        (err)
`ifdef WRITEBACK_FORWARDING_EN
    ,
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
`endif
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [3:0]  ird;
    logic        av;
    logic [3:0]  ard;
    logic [15:0] ad;
    logic        mv;
    logic [3:0]  mrd;
    logic [15:0] md;
    logic        rdy;
    logic [15:0] en;
    logic [15:0] wd;
    logic [15:0] pend;
    logic        err;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [15:0] en;
    logic [15:0] wd;
    logic [15:0] pend;
    logic        err;
    logic        busy;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[24];
  logic [15:0] rf[16];
  int          n_vec  = 0;
  int          n_fail = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) if (wr_en[i]) rf[i] <= wr_data;
  end

  function automatic vec_t mk(input logic r, input logic iv, input logic [3:0] ird,
                              input logic av, input logic [3:0] ard, input logic [15:0] ad,
                              input logic mv, input logic [3:0] mrd, input logic [15:0] md,
                              input logic rdy, input logic [15:0] en, input logic [15:0] wd,
                              input logic [15:0] pend, input logic e, input logic b);
    vec_t v;
    v.rst = r; v.iv = iv; v.ird = ird; v.av = av; v.ard = ard; v.ad = ad;
    v.mv = mv; v.mrd = mrd; v.md = md; v.rdy = rdy; v.en = en; v.wd = wd;
    v.pend = pend; v.err = e; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, check ready, queue expectation, then compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    rst         = v.rst;
    issue_valid = v.iv;
    issue_load  = v.iv;
    issue_rd    = v.ird;
    alu_valid   = v.av;
    alu_rd      = v.ard;
    alu_data    = v.ad;
    mem_valid   = v.mv;
    mem_rd      = v.mrd;
    mem_data    = v.md;
    #1;
    chk("alu_ready", {15'd0, alu_ready}, {15'd0, v.rdy});
    sb.push_back('{en: v.en, wd: v.wd, pend: v.pend, err: v.err, busy: v.busy});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("wr_en", wr_en, e.en);
    if (e.en != 16'h0) chk("wr_data", wr_data, e.wd);
    chk("pending", pending, e.pend);
    chk("err", {15'd0, err}, {15'd0, e.err});
    chk("busy", {15'd0, busy}, {15'd0, e.busy});
  endtask

  initial begin
    rst = 1'b1; issue_valid = 0; issue_load = 0; issue_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0; mem_valid = 0; mem_rd = 0; mem_data = 0;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;

    //            rst iv ird av ard ad       mv mrd md      rdy en        wd       pend     err busy
    vecs[0]  = mk(0, 0, 0,  1, 3,  16'h0123, 0, 0,  16'h0,  1, 16'h0008, 16'h0123, 16'h0000, 0, 0);
    vecs[1]  = mk(0, 0, 0,  0, 0,  16'h0,    0, 0,  16'h0,  1, 16'h0000, 16'h0,    16'h0000, 0, 0);
    vecs[2]  = mk(0, 1, 2,  0, 0,  16'h0,    0, 0,  16'h0,  1, 16'h0000, 16'h0,    16'h0004, 0, 1);
    vecs[3]  = mk(0, 0, 0,  1, 7,  16'h4545, 1, 2,  16'hAEAE, 1, 16'h0004, 16'hAEAE, 16'h0000, 0, 1);
    vecs[4]  = mk(0, 0, 0,  1, 7,  16'h4545, 0, 0,  16'h0,  0, 16'h0080, 16'h4545, 16'h0000, 0, 0);
    vecs[5]  = mk(0, 0, 0,  0, 0,  16'h0,    0, 0,  16'h0,  1, 16'h0000, 16'h0,    16'h0000, 0, 0);
    vecs[6]  = mk(0, 1, 5,  0, 0,  16'h0,    0, 0,  16'h0,  1, 16'h0000, 16'h0,    16'h0020, 0, 1);
    vecs[7]  = mk(0, 0, 0,  1, 5,  16'h1111, 1, 5,  16'h2222, 1, 16'h0020, 16'h2222, 16'h0000, 0, 1);
    vecs[8]  = mk(0, 0, 0,  0, 0,  16'h0,    0, 0,  16'h0,  0, 16'h0020, 16'h1111, 16'h0000, 0, 0);
    vecs[9]  = mk(0, 0, 0,  0, 0,  16'h0,    0, 0,  16'h0,  1, 16'h0000, 16'h0,    16'h0000, 0, 0);
    vecs[10] = mk(0, 1, 15, 0, 0,  16'h0,    0, 0,  16'h0,  1, 16'h0000, 16'h0,    16'h8000, 0, 1);
    vecs[11] = mk(0, 0, 0,  0, 0,  16'h0,    1, 15, 16'hBEEF, 1, 16'h8000, 16'hBEEF, 16'h0000, 0, 0);
    vecs[12] = mk(0, 1, 1,  0, 0,  16'h0,    0, 0,  16'h0,  1, 16'h0000, 16'h0,    16'h0002, 0, 1);
    vecs[13] = mk(0, 1, 1,  0, 0,  16'h0,    1, 1,  16'h5A5A, 1, 16'h0002, 16'h5A5A, 16'h0002, 0, 1);
    vecs[14] = mk(0, 0, 0,  0, 0,  16'h0,    1, 1,  16'h0101, 1, 16'h0002, 16'h0101, 16'h0000, 0, 0);
    vecs[15] = mk(0, 1, 9,  0, 0,  16'h0,    0, 0,  16'h0,  1, 16'h0000, 16'h0,    16'h0200, 0, 1);
    vecs[16] = mk(0, 1, 10, 0, 0,  16'h0,    0, 0,  16'h0,  1, 16'h0000, 16'h0,    16'h0600, 0, 1);
    vecs[17] = mk(0, 0, 0,  1, 0,  16'hFFFF, 1, 9,  16'h0909, 1, 16'h0200, 16'h0909, 16'h0400, 0, 1);
    vecs[18] = mk(0, 0, 0,  0, 0,  16'h0,    1, 10, 16'h1010, 0, 16'h0400, 16'h1010, 16'h0000, 0, 1);
    vecs[19] = mk(0, 0, 0,  0, 0,  16'h0,    0, 0,  16'h0,  0, 16'h0001, 16'hFFFF, 16'h0000, 0, 0);
    vecs[20] = mk(0, 0, 0,  0, 0,  16'h0,    0, 0,  16'h0,  1, 16'h0000, 16'h0,    16'h0000, 0, 0);
    vecs[21] = mk(0, 0, 0,  0, 0,  16'h0,    1, 4,  16'h4444, 1, 16'h0010, 16'h4444, 16'h0000, 1, 0);
    vecs[22] = mk(0, 0, 0,  0, 0,  16'h0,    0, 0,  16'h0,  1, 16'h0000, 16'h0,    16'h0000, 1, 0);
    vecs[23] = mk(0, 0, 0,  1, 3,  16'h3333, 0, 0,  16'h0,  1, 16'h0008, 16'h3333, 16'h0000, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 16'h0);
    chk("rst_wr_data", wr_data, 16'h0);
    chk("rst_pending", pending, 16'h0);
    chk("rst_err", {15'd0, err}, 16'h0);
    chk("rst_busy", {15'd0, busy}, 16'h0);
    chk("rst_alu_ready", {15'd0, alu_ready}, 16'h1);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      apply(vecs[i]);
      if (i == 9) chk("rf5_final", rf[5], 16'h1111);
    end

    // Reset while the skid is full: contents and pending bits are dropped, err clears.
    apply(mk(0, 1, 12, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h0000, 16'h0,    16'h1000, 1, 1));
    apply(mk(0, 1, 6,  0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h0000, 16'h0,    16'h1040, 1, 1));
    apply(mk(0, 0, 0,  1, 8, 16'h8888, 1, 6, 16'h6666, 1, 16'h0040, 16'h6666, 16'h1000, 1, 1));
    apply(mk(1, 0, 0,  0, 0, 16'h0,    0, 0, 16'h0,    0, 16'h0000, 16'h0,    16'h0000, 0, 0));
    apply(mk(0, 0, 0,  0, 0, 16'h0,    0, 0, 16'h0,    1, 16'h0000, 16'h0,    16'h0000, 0, 0));
    chk("rf8_untouched", rf[8], 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage of the LITE-16 core, sitting between the execute/memory stages and the 16×16-bit register file. It accepts results from the ALU and from the memory load-return path, and arbitrates them onto the register file's single write port (data plus one-hot enable). It also tracks outstanding loads in a per-register scoreboard so the register fetch unit can stall on hazards.

## Interface
Parameters:
- REG_COUNT, 16, number of architectural registers (one-hot enable width)
- REG_W, 16, register data width
- IDX_W, 4, register index width (log2 REG_COUNT)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  fetch unit issues an instruction this cycle
- issue_load  in  1  issued instruction is a load (result returns on mem path)
- issue_rd  in  IDX_W  destination of issued instruction
- alu_valid  in  1  ALU result offered
- alu_rd  in  IDX_W  ALU destination register
- alu_data  in  REG_W  ALU result
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
- mem_valid  in  1  load data returned (always accepted, no ready)
- mem_rd  in  IDX_W  load destination register
- mem_data  in  REG_W  load data
- wr_data  out  REG_W  register file data_in
- wr_en  out  REG_COUNT  register file one-hot write enable
- pending  out  REG_COUNT  bit i set = load to register i outstanding
- busy  out  1  skid buffer full or any pending bit set
- err  out  1  sticky: mem_valid arrived for a register not pending

## Operation
- Skid FSM, states EMPTY and FULL; alu_ready = (state == EMPTY).
- EMPTY, mem_valid only: write mem; stay EMPTY.
- EMPTY, ALU accepted only: write ALU; stay EMPTY.
- EMPTY, both: write mem; capture alu_rd/alu_data into the skid; go FULL.
- FULL, mem_valid: write mem; stay FULL (the skid is held).
- FULL, no mem_valid: write the skid entry; go EMPTY.
- alu_valid while alu_ready=0: ignored. The source must hold its data stable.
- Memory always has priority over the ALU. If both target the same register in the same cycle, mem is written first and the ALU value is written next, so the ALU value is final.
- Scoreboard:
  - issue_valid && issue_load sets pending[issue_rd].
  - mem_valid clears pending[mem_rd].
  - A set and a clear of the same bit in the same cycle: set wins.
- mem_valid with pending[mem_rd]=0: the write is still performed and err sets.
- ALU writes never touch pending.
- At most one wr_en bit is set per cycle. wr_en is all-zero in cycles with nothing to write.

## Timing
- wr_en/wr_data are registered: asserted in the cycle after acceptance, for exactly one cycle per write. The register file captures the value on the following edge.
- Throughput: one write per cycle. The skid adds one cycle of ALU latency on a collision.
- pending updates at the edge where issue or mem_valid is sampled. busy and alu_ready derive combinationally from registered state.
- Reset values:
  - wr_en=0, wr_data=0, pending=0, err=0, busy=0
  - state EMPTY, so alu_ready=1
- Reset mid-operation: skid contents discarded, outstanding pending bits dropped, no write issued in the cycle after reset.

## Configuration
- Macro WRITEBACK_FORWARDING_EN.
- Defined: adds outputs fwd_valid (1), fwd_rd (IDX_W), fwd_data (REG_W), driven combinationally with the write selected this cycle, i.e. the value wr_* will carry next cycle. This lets the fetch unit bypass.
- Undefined: the ports are absent and there is no combinational input-to-output path.

## Structure
- Shared package/header lite16_pkg:
  - REG_COUNT, REG_W, IDX_W
  - register index type
  - skid state encoding (EMPTY=0, FULL=1)
- Sub-module onehot_decoder (IDX_W-to-REG_COUNT, with an enable) generates wr_en from the selected index. The register fetch unit can reuse it.

## Test plan
- After reset: alu_valid, alu_rd=3, alu_data=0x0123 for one cycle -> next cycle wr_en=0x0008, wr_data=0x0123; then wr_en=0.
- Collision: alu(rd=7, 0x4545) and mem(rd=2, 0xAEAE) in the same cycle -> alu_ready low for one cycle; wr_en=0x0004/0xAEAE, then 0x0080/0x4545.
- Same-register collision: alu(rd=5, 0x1111) and mem(rd=5, 0x2222) -> writes 0x2222, then 0x1111; register 5 ends at 0x1111.
- Scoreboard:
  - issue load rd=15 -> pending=0x8000 and busy=1.
  - mem rd=15, 0xBEEF -> pending=0, write 0xBEEF, err=0.
  - Issue load rd=1 in the same cycle as mem rd=1 -> pending[1] stays 1.
- Stray load: mem_valid rd=4 with no pending bit -> write performed, err=1 and it stays set until rst.
- Reset while FULL: collision cycle, then rst=1 -> no skid write, wr_en=0, alu_ready=1, pending=0.
